// File: rtl/dbus_arbiter.sv
// Round-robin arbiter giving the CPU data bus (m0) and a second requester (m1)
// shared access to one slave port, with a single outstanding read and a read watchdog.
module dbus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_W-1:0]     m0_addr_i,
  input  logic [DATA_W-1:0]     m0_wdata_i,
  input  logic [DATA_W/8-1:0]   m0_wstrb_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_W-1:0]     m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_W-1:0]     m1_addr_i,
  input  logic [DATA_W-1:0]     m1_wdata_i,
  input  logic [DATA_W/8-1:0]   m1_wstrb_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_W-1:0]     m1_rdata_o,
  output logic                  s_req_o,
  output logic                  s_we_o,
  output logic [ADDR_W-1:0]     s_addr_o,
  output logic [DATA_W-1:0]     s_wdata_o,
  output logic [DATA_W/8-1:0]   s_wstrb_o,
  input  logic                  s_ready_i,
  input  logic                  s_rvalid_i,
  input  logic [DATA_W-1:0]     s_rdata_i,
  output logic                  err_o
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_WAIT = 1'b1;
  // The watchdog fires in the wait cycle whose increment would reach RD_TIMEOUT.
  localparam logic [15:0] TMO_LAST = 16'(RD_TIMEOUT - 1);

  logic [0:0]        state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              owner_q, owner_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic              arb_en;
  logic              sel;
  logic              sel_req;
  logic              gnt_any;
  logic              deliver;
  logic [DATA_W-1:0] deliver_dat;

  // No arbitration while a read is outstanding or its response is being returned.
  assign arb_en = (state_q == IDLE) && !m0_rvalid_q && !m1_rvalid_q;

  always_comb begin
    if (m0_req_i && m1_req_i) begin
      sel = ~last_gnt_q;
    end else begin
      sel = m1_req_i;
    end
  end

  assign sel_req   = sel ? m1_req_i : m0_req_i;
  assign s_req_o   = arb_en && sel_req;
  assign s_we_o    = sel ? m1_we_i    : m0_we_i;
  assign s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
  assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
  assign s_wstrb_o = sel ? m1_wstrb_i : m0_wstrb_i;

  assign m0_gnt_o = arb_en && !sel && m0_req_i && s_ready_i;
  assign m1_gnt_o = arb_en &&  sel && m1_req_i && s_ready_i;
  assign gnt_any  = m0_gnt_o || m1_gnt_o;

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    deliver     = 1'b0;
    deliver_dat = '0;

    case (state_q)
      IDLE: begin
        if (s_rvalid_i) begin
          err_d = 1'b1;
        end
        if (gnt_any) begin
          last_gnt_d = m1_gnt_o;
          if (!s_we_o) begin
            state_d = RD_WAIT;
            owner_d = m1_gnt_o;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        if (s_rvalid_i) begin
          deliver     = 1'b1;
          deliver_dat = s_rdata_i;
        end else if (cnt_q == TMO_LAST) begin
          deliver = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    endcase

    if (deliver) begin
      state_d = IDLE;
      cnt_d   = '0;
      if (owner_q) begin
        m1_rvalid_d = 1'b1;
        m1_rdata_d  = deliver_dat;
      end else begin
        m0_rvalid_d = 1'b1;
        m0_rdata_d  = deliver_dat;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_rvalid_o = m0_rvalid_q;
  assign m1_rvalid_o = m1_rvalid_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;
  assign err_o       = err_q;

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Two-requester round-robin arbiter sharing one data-memory/MMIO slave port between the CPU data bus (m0) and a second requester (m1), such as a CFU DMA or display-refresh engine.
- Sits between the requesters and the data memory inside main.
- Allows at most one outstanding read.
- Includes a read-timeout watchdog so a dead slave cannot hang the pipeline.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- RD_TIMEOUT, 255, maximum cycles a read may stay outstanding before the arbiter forces a response (legal range 1..65535).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- m0_req_i  in  1  request valid; held until granted
- m0_we_i  in  1  1=write, 0=read
- m0_addr_i  in  ADDR_W  address
- m0_wdata_i  in  DATA_W  write data
- m0_wstrb_i  in  DATA_W/8  byte strobes
- m0_gnt_o  out  1  request accepted this cycle
- m0_rvalid_o  out  1  read data valid (1-cycle pulse)
- m0_rdata_o  out  DATA_W  read data
- m1_*: same set as m0 for requester 1
- s_req_o  out  1  request to slave
- s_we_o, s_addr_o, s_wdata_o, s_wstrb_o  out  as above  muxed request fields
- s_ready_i  in  1  slave accepts request this cycle
- s_rvalid_i  in  1  slave read response valid
- s_rdata_i  in  DATA_W  slave read data
- err_o  out  1  sticky error flag: timeout or unexpected response

Behaviour:
- Clock is clk_i. Reset is synchronous, active-high, on rst_i. No other clock.
- Reset values:
  - state=IDLE, last_gnt=1 (m0 wins first), timeout counter=0.
  - err_o=0, all gnt/rvalid outputs 0, rdata outputs 0.
  - s_req_o=0.
- States:
  - IDLE: accepting requests.
  - RD_WAIT: one read outstanding; owner register holds 0 or 1.
- Selection in IDLE (combinational from inputs and registers):
  - Only one requesting: select it.
  - Both requesting: select the one not equal to last_gnt.
  - s_req_o = selected req. s_we/addr/wdata/wstrb follow the selected master. If none is requesting, drive m0's fields with s_req_o=0.
- Grant:
  - mX_gnt_o = IDLE & selected==X & mX_req_i & s_ready_i.
  - Zero-cycle issue: the request is accepted in the same cycle gnt is high.
  - On grant, last_gnt<=X.
  - Granted write: stay in IDLE; back-to-back writes are possible every cycle.
  - Granted read: go to RD_WAIT, owner<=X, counter<=0.
- RD_WAIT:
  - s_req_o=0 and no grants.
  - Counter increments each cycle.
  - On s_rvalid_i: next cycle, owner's rvalid_o=1 and rdata_o=s_rdata_i (registered, 1-cycle latency), counter cleared, state->IDLE.
  - New requests are arbitrated from the cycle after rvalid_o is asserted.
- Timeout:
  - If the counter reaches RD_TIMEOUT with no s_rvalid_i: owner rvalid_o=1 with rdata_o=0, err_o<=1, state->IDLE.
  - If s_rvalid_i arrives in the same cycle the counter reaches RD_TIMEOUT, the real data wins and there is no error.
- Unexpected response:
  - s_rvalid_i in IDLE is ignored (no rvalid_o to either master) and sets err_o.
  - A late response after a timeout is handled the same way.
- Non-owner outputs:
  - The non-owner's rvalid_o stays 0.
  - Both rdata_o outputs hold their last value when rvalid_o=0.
- Requester rules:
  - A requester must hold req and its fields stable until gnt.
  - Dropping req before gnt is legal; the arbiter never grants a deasserted req.
- Fairness: with both requesting continuously, grants alternate strictly (m0,m1,m0,...). No requester waits more than one other transaction.
- Reset mid-read: state returns to IDLE with no rvalid_o. The slave shares rst_i, so no stale response is expected. err_o clears only on reset.

Test Plan:
- After reset, both request writes continuously with s_ready_i=1 -> gnt pattern m0,m1,m0,m1 on consecutive cycles; s_addr_o matches the granted master.
- m1 reads addr 0x10; slave returns s_rvalid_i 3 cycles after grant with data 0xDEADBEEF -> m1_rvalid_o pulses one cycle later with 0xDEADBEEF. m0_rvalid_o stays 0, and no grant occurs during RD_WAIT even with m0_req_i high.
- m0 write with s_ready_i=0 for 4 cycles -> no gnt and req held. Ready rises -> gnt in that cycle. last_gnt flips to m0, so m1 wins the next contention.
- RD_TIMEOUT=8, m0 read with no response -> m0_rvalid_o=1 with rdata 0 exactly 8 cycles after entering RD_WAIT (response cycle inclusive); err_o=1 thereafter. A later s_rvalid_i in IDLE produces no rvalid_o.
- s_rvalid_i in the same cycle the counter hits RD_TIMEOUT -> real data is delivered and err_o stays 0.
- Assert rst_i for 1 cycle during RD_WAIT -> next cycle: IDLE, err_o=0, no rvalid_o; m0 has priority on the next contention.
